serial_addsub: RTL and testbench
================================

// Module: serial_addsub
// PURPOSE
//  Multi-cycle, parametrised, bit-serial adder/subtractor built from a 1-bit-cell slice.
//  - Generalises the single full-adder cell to a WIDTH-bit operation processed DIGIT_W bits per cycle.
//  - Adds a subtract mode, an overflow flag and a valid/ready handshake on input and output.
//  - Sits between a register-file/operand source and a result consumer in lab datapaths.
// PARAMETERS
//  WIDTH    8  operand/result width in bits (>=2)
//  DIGIT_W  1  bits processed per cycle; WIDTH % DIGIT_W == 0 (elaboration error otherwise)
// PORTS
//  clk         in   1        single clock, rising edge
//  rst_n       in   1        synchronous, active-low reset
//  in_valid    in   1        operands a, b, sub, cin valid
//  in_ready    out  1        block can accept operands
//  a           in   WIDTH    operand A (two's complement or unsigned)
//  b           in   WIDTH    operand B
//  sub         in   1        1: A - B; 0: A + B + cin
//  cin         in   1        carry-in, used only when sub=0
//  out_valid   out  1        result fields valid
//  out_ready   in   1        consumer accepts result
//  sum         out  WIDTH    result
//  cout        out  1        carry out of MSB (for sub: 1 = no borrow)
//  ovf         out  1        signed overflow = carry into MSB XOR carry out of MSB
// BEHAVIOUR
//  - Reset: the one clock domain (clk) uses synchronous, active-low reset rst_n.
//    While rst_n=0 at a clk edge: state=IDLE, in_ready=0 during reset, 1 the cycle after.
//    Also at reset: out_valid=0, sum=0, cout=0, ovf=0.
//  - Reset mid-operation aborts the operation; no partial result is ever presented.
//  - FSM states:
//    IDLE: in_ready=1. in_valid&in_ready at an edge latches a, b^{WIDTH{sub}}, and carry=sub?1:cin. Next state RUN, counter=0.
//    RUN: in_ready=0. Each cycle, DIGIT_W cells add the operand LSB digits plus carry.
//      The result digit shifts into sum from the MSB side; operands shift right by DIGIT_W.
//      After N=WIDTH/DIGIT_W RUN cycles, latch cout/ovf and go to DONE.
//    DONE: out_valid=1; sum/cout/ovf stable until out_valid&out_ready, then IDLE.
//  - Latency: handshake at edge k gives out_valid=1 after edge k+N.
//    Throughput: one op per N+2 cycles with out_ready held at 1.
//  - in_valid is ignored outside IDLE. Operand inputs are only sampled at the accepting edge and may change afterwards.
//  - No bypass: a DONE->IDLE transition and a new accept cannot share a cycle; in_ready rises the cycle after the result is taken.
//  - Back-pressure: out_ready=0 holds DONE indefinitely, with outputs frozen.
//  - Internal sum register: not cleared between ops. Ignore its content unless out_valid=1.
//  - Width rules:
//    Result is mod 2^WIDTH.
//    ovf uses the carry into bit WIDTH-1, captured in the last RUN cycle.
//    Counter width is $clog2(N+1).
// STRUCTURE
//  - Package serial_addsub_pkg:
//    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t
//    function n_digits(WIDTH, DIGIT_W)
//  - Sub-module fa_cell: 1-bit full adder (x, y, ci -> s, co), instantiated DIGIT_W times in a ripple chain per cycle.
//  - Top: FSM, operand shift registers, digit counter, result shift register, flags.
// TESTING
//  - Reset: rst_n=0 for 2 cycles mid-RUN -> next cycle state IDLE, out_valid=0, sum=0, then in_ready=1.
//  - Add, WIDTH=8, DIGIT_W=1: a=8'h5A, b=8'h3C, sub=0, cin=1 -> after 8 cycles sum=8'h97, cout=0, ovf=1.
//  - Subtract, WIDTH=8: a=8'h10, b=8'h20, sub=1 -> sum=8'hF0, cout=0 (borrow), ovf=0.
//    Also a=8'h80, b=8'h01, sub=1 -> sum=8'h7F, cout=1, ovf=1.
//  - Wrap, WIDTH=8, DIGIT_W=4: a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1, ovf=0.
//    Also check out_valid exactly 2 edges after accept.
//  - Back-pressure: hold out_ready=0 for 5 cycles in DONE while toggling in_valid/a -> sum unchanged, in_ready=0.
//    Then out_ready=1 -> IDLE, next op accepted one cycle later.
//  - Exhaustive, WIDTH=4, DIGIT_W in {1,2,4}: all a, b, sub, cin -> sum/cout/ovf match a reference model.

Source files
------------

// File: rtl/serial_addsub_pkg.sv
// Shared types and helpers for the bit-serial adder/subtractor.
package serial_addsub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Number of RUN cycles needed for one operation.
    function automatic int unsigned n_digits(input int unsigned width, input int unsigned digit_w);
        return width / digit_w;
    endfunction

endpackage

// File: rtl/serial_addsub_fa_cell.sv
// One-bit full adder cell; chained DIGIT_W times per cycle by serial_addsub.
module fa_cell (
    input  logic x,
    input  logic y,
    input  logic ci,
    output logic s,
    output logic co
);

    // Sum and carry of a single bit position.
    assign s  = x ^ y ^ ci;
    assign co = (x & y) | (ci & (x ^ y));

endmodule

// File: rtl/serial_addsub.sv
// Multi-cycle bit-serial adder/subtractor, DIGIT_W bits per cycle, valid/ready on both sides.
module serial_addsub
    import serial_addsub_pkg::*;
#(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned DIGIT_W = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned N  = n_digits(WIDTH, DIGIT_W);
    localparam int unsigned CW = $clog2(N + 1);

    // Reject parameter sets that cannot be split into whole digits.
    if ((WIDTH < 2) || (DIGIT_W == 0) || ((WIDTH % DIGIT_W) != 0)) begin : g_bad_params
        $error("serial_addsub: WIDTH must be >= 2 and a multiple of DIGIT_W");
    end

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic              carry_q, carry_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]  sum_q, sum_d;
    logic              cout_q, cout_d;
    logic              ovf_q, ovf_d;
    logic              in_ready_q, in_ready_d;
    logic              out_valid_q, out_valid_d;

    logic [DIGIT_W:0]   c;
    logic [DIGIT_W-1:0] s_dig;

    assign c[0] = carry_q;

    // Ripple chain over the current low digit of the operand shift registers.
    for (genvar i = 0; i < DIGIT_W; i++) begin : g_cell
        fa_cell u_fa (
            .x  (a_q[i]),
            .y  (b_q[i]),
            .ci (c[i]),
            .s  (s_dig[i]),
            .co (c[i+1])
        );
    end

    // Next-state, datapath and output decode.
    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        carry_d     = carry_q;
        cnt_d       = cnt_q;
        sum_d       = sum_q;
        cout_d      = cout_q;
        ovf_d       = ovf_q;

        case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    state_d = RUN;
                    a_d     = a;
                    b_d     = b ^ {WIDTH{sub}};
                    carry_d = sub | cin;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                a_d     = a_q >> DIGIT_W;
                b_d     = b_q >> DIGIT_W;
                carry_d = c[DIGIT_W];
                sum_d   = WIDTH'({s_dig, sum_q} >> DIGIT_W);
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CW'(N - 1)) begin
                    state_d = DONE;
                    cout_d  = c[DIGIT_W];
                    ovf_d   = c[DIGIT_W] ^ c[DIGIT_W-1];
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            carry_q     <= 1'b0;
            cnt_q       <= '0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            carry_q     <= carry_d;
            cnt_q       <= cnt_d;
            sum_q       <= sum_d;
            cout_q      <= cout_d;
            ovf_q       <= ovf_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_serial_addsub.sv
// Directed and exhaustive checks of serial_addsub over several WIDTH/DIGIT_W pairs.
module tb_serial_addsub;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    // Instance 0: W8 D1, 1: W8 D4, 2: W4 D1, 3: W4 D2, 4: W4 D4.
    logic [7:0] a_v[5], b_v[5], sum_v[5];
    logic       sub_v[5], cin_v[5], inv_v[5], ordy_v[5];
    logic       ir_v[5], ov_v[5], co_v[5], of_v[5];

    int n_checks = 0;
    int n_fail   = 0;

    for (genvar g = 0; g < 5; g++) begin : g_dut
        localparam int unsigned W = (g < 2) ? 8 : 4;
        localparam int unsigned D = (g == 0) ? 1 : (g == 1) ? 4 : (g == 2) ? 1 : (g == 3) ? 2 : 4;
        logic [W-1:0] s_w;
        serial_addsub #(.WIDTH(W), .DIGIT_W(D)) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (inv_v[g]),
            .in_ready  (ir_v[g]),
            .a         (a_v[g][W-1:0]),
            .b         (b_v[g][W-1:0]),
            .sub       (sub_v[g]),
            .cin       (cin_v[g]),
            .out_valid (ov_v[g]),
            .out_ready (ordy_v[g]),
            .sum       (s_w),
            .cout      (co_v[g]),
            .ovf       (of_v[g])
        );
        assign sum_v[g] = 8'(s_w);
    end

    function automatic int ndig(input int i);
        case (i)
            0:       return 8;
            1:       return 2;
            2:       return 4;
            3:       return 2;
            default: return 1;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Issue one operation on instance i, check latency, return the result and take it.
    task automatic do_op(input int i, input logic [7:0] a, input logic [7:0] b,
                         input logic s, input logic c,
                         output logic [7:0] rs, output logic rc, output logic ro);
        int cnt;
        cnt = 0;
        while (!ir_v[i] && cnt < 50) begin
            @(negedge clk);
            cnt++;
        end
        check("ready_wait", 32'(ir_v[i]), 1);
        a_v[i]   = a;
        b_v[i]   = b;
        sub_v[i] = s;
        cin_v[i] = c;
        inv_v[i] = 1'b1;
        @(negedge clk);
        inv_v[i] = 1'b0;
        a_v[i]   = 8'($urandom);
        b_v[i]   = 8'($urandom);
        cnt = 0;
        while (!ov_v[i] && cnt < 50) begin
            @(negedge clk);
            cnt++;
        end
        check("latency", 32'(cnt), 32'(ndig(i)));
        rs = sum_v[i];
        rc = co_v[i];
        ro = of_v[i];
        ordy_v[i] = 1'b1;
        @(negedge clk);
        ordy_v[i] = 1'b0;
        check("take_ready", 32'(ir_v[i]), 1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] rs;
        logic       rc, ro;
        logic [3:0] a4, bb;
        logic [4:0] full;
        logic       cc, om, sm;
        int         cnt;

        for (int i = 0; i < 5; i++) begin
            a_v[i] = '0; b_v[i] = '0; sub_v[i] = 1'b0; cin_v[i] = 1'b0;
            inv_v[i] = 1'b0; ordy_v[i] = 1'b0;
        end

        // Reset state
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_in_ready", 32'(ir_v[0]), 0);
        check("rst_out_valid", 32'(ov_v[0]), 0);
        check("rst_sum", 32'(sum_v[0]), 0);
        check("rst_cout", 32'(co_v[0]), 0);
        check("rst_ovf", 32'(of_v[0]), 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_ready_rise", 32'(ir_v[0]), 1);

        // Add with carry-in
        do_op(0, 8'h5A, 8'h3C, 1'b0, 1'b1, rs, rc, ro);
        check("add_sum", 32'(rs), 32'h97);
        check("add_cout", 32'(rc), 0);
        check("add_ovf", 32'(ro), 1);

        // Subtract with borrow; cin set to 1 must be ignored
        do_op(0, 8'h10, 8'h20, 1'b1, 1'b1, rs, rc, ro);
        check("sub1_sum", 32'(rs), 32'hF0);
        check("sub1_cout", 32'(rc), 0);
        check("sub1_ovf", 32'(ro), 0);

        do_op(0, 8'h80, 8'h01, 1'b1, 1'b0, rs, rc, ro);
        check("sub2_sum", 32'(rs), 32'h7F);
        check("sub2_cout", 32'(rc), 1);
        check("sub2_ovf", 32'(ro), 1);

        // Wrap with 4-bit digits, latency 2
        do_op(1, 8'hFF, 8'h01, 1'b0, 1'b0, rs, rc, ro);
        check("wrap_sum", 32'(rs), 32'h00);
        check("wrap_cout", 32'(rc), 1);
        check("wrap_ovf", 32'(ro), 0);

        // Back-pressure: DONE held with out_ready low while inputs toggle
        a_v[0] = 8'h12; b_v[0] = 8'h34; sub_v[0] = 1'b0; cin_v[0] = 1'b0; inv_v[0] = 1'b1;
        @(negedge clk);
        inv_v[0] = 1'b0;
        cnt = 0;
        while (!ov_v[0] && cnt < 50) begin
            @(negedge clk);
            cnt++;
        end
        check("bp_latency", 32'(cnt), 8);
        for (int k = 0; k < 5; k++) begin
            inv_v[0] = ~inv_v[0];
            a_v[0]   = 8'($urandom);
            @(negedge clk);
            check("bp_sum", 32'(sum_v[0]), 32'h46);
            check("bp_in_ready", 32'(ir_v[0]), 0);
            check("bp_out_valid", 32'(ov_v[0]), 1);
        end
        inv_v[0]  = 1'b0;
        ordy_v[0] = 1'b1;
        @(negedge clk);
        ordy_v[0] = 1'b0;
        check("bp_release_valid", 32'(ov_v[0]), 0);
        check("bp_release_ready", 32'(ir_v[0]), 1);
        a_v[0] = 8'h01; b_v[0] = 8'h02; inv_v[0] = 1'b1;
        @(negedge clk);
        inv_v[0] = 1'b0;
        check("bp_next_accept", 32'(ir_v[0]), 0);
        cnt = 0;
        while (!ov_v[0] && cnt < 50) begin
            @(negedge clk);
            cnt++;
        end
        check("bp_next_sum", 32'(sum_v[0]), 32'h03);
        ordy_v[0] = 1'b1;
        @(negedge clk);
        ordy_v[0] = 1'b0;

        // Reset mid-RUN aborts the operation
        a_v[0] = 8'hA5; b_v[0] = 8'h11; sub_v[0] = 1'b0; cin_v[0] = 1'b0; inv_v[0] = 1'b1;
        @(negedge clk);
        inv_v[0] = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("mid_rst_ready", 32'(ir_v[0]), 0);
        check("mid_rst_valid", 32'(ov_v[0]), 0);
        check("mid_rst_sum", 32'(sum_v[0]), 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("mid_rst_ready_rise", 32'(ir_v[0]), 1);
        check("mid_rst_no_result", 32'(ov_v[0]), 0);

        // Exhaustive 4-bit against an arithmetic reference
        for (int i = 2; i < 5; i++) begin
            for (int av = 0; av < 16; av++) begin
                for (int bv = 0; bv < 16; bv++) begin
                    for (int m = 0; m < 3; m++) begin
                        a4   = 4'(av);
                        sm   = (m == 2);
                        cc   = (m == 1);
                        bb   = sm ? ~4'(bv) : 4'(bv);
                        full = {1'b0, a4} + {1'b0, bb} + 5'(sm | cc);
                        om   = (a4[3] == bb[3]) && (full[3] != a4[3]);
                        do_op(i, 8'(av), 8'(bv), sm, sm ? a4[0] : cc, rs, rc, ro);
                        check($sformatf("exh i%0d a%0h b%0h m%0d", i, av, bv, m),
                              32'({rs[3:0], rc, ro}), 32'({full[3:0], full[4], om}));
                    end
                end
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
